// File: rtl/nubus_cpu_arbiter.sv
// ---------------------------------------------------------------------------
// nubus_cpu_arbiter
//    Two-requester front end for a single NuBus master. The arbiter grants one
//    requester at a time (round-robin, with optional bus locking), registers the
//    granted request onto the cpu_* master interface, waits for the master to
//    complete or for a timeout, and returns a one-cycle completion pulse with
//    read data and an error flag to the granted requester.
//
// Parameters
//    TIMEOUT_CLOCKS  BUSY cycles allowed before the transfer is aborted (1..255)
//    ERR_RDATA       read data returned on an aborted transfer
//
// Ports
//    cpu_clk_i, cpu_reset_i        clock, synchronous active-high reset
//    sN_valid_i/addr_i/wdata_i     requester N request (held until sN_ready_o)
//    sN_write_i                    byte strobes, 0 = read
//    sN_lock_i                     keep bus ownership after this transfer
//    sN_ready_o/rdata_o/err_o      completion pulse, read data, timeout flag
//    cpu_valid_o/addr_o/wdata_o    request to the NuBus master
//    cpu_write_o, cpu_lock_o       strobes and lock of the granted request
//    cpu_ready_i, cpu_rdata_i      master completion and read data
//    arb_grant_o, arb_busy_o       current owner index, transfer in flight
//
// State table
//    state      | meaning
//    ST_IDLE    | no transfer; arbitrate (only the owner is considered if locked)
//    ST_BUSY    | request presented to the master, timeout counter running
//    ST_RELEASE | one dead cycle after completion; requests are ignored
// ---------------------------------------------------------------------------
module nubus_cpu_arbiter #(
   parameter int unsigned TIMEOUT_CLOCKS = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
   input  logic        cpu_clk_i,
   input  logic        cpu_reset_i,
   input  logic        s0_valid_i,
   input  logic [31:0] s0_addr_i,
   input  logic [31:0] s0_wdata_i,
   input  logic [3:0]  s0_write_i,
   input  logic        s0_lock_i,
   output logic        s0_ready_o,
   output logic [31:0] s0_rdata_o,
   output logic        s0_err_o,
   input  logic        s1_valid_i,
   input  logic [31:0] s1_addr_i,
   input  logic [31:0] s1_wdata_i,
   input  logic [3:0]  s1_write_i,
   input  logic        s1_lock_i,
   output logic        s1_ready_o,
   output logic [31:0] s1_rdata_o,
   output logic        s1_err_o,
   output logic        cpu_valid_o,
   output logic [31:0] cpu_addr_o,
   output logic [31:0] cpu_wdata_o,
   output logic [3:0]  cpu_write_o,
   output logic        cpu_lock_o,
   input  logic        cpu_ready_i,
   input  logic [31:0] cpu_rdata_i,
   output logic        arb_grant_o,
   output logic        arb_busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   // The counter holds the number of BUSY cycles already completed, so the
   // abort fires at the end of the TIMEOUT_CLOCKS-th BUSY cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CLOCKS - 1);

   state_e      state_q;
   logic        lock_q;
   logic        last_q;
   logic        grant_q;
   logic [7:0]  cnt_q;
   logic        cpu_valid_q;
   logic [31:0] cpu_addr_q;
   logic [31:0] cpu_wdata_q;
   logic [3:0]  cpu_write_q;
   logic        s0_ready_q;
   logic        s1_ready_q;
   logic        s0_err_q;
   logic        s1_err_q;
   logic [31:0] s0_rdata_q;
   logic [31:0] s1_rdata_q;
   logic        arb_busy_q;

   logic        grant_en_d;
   logic        grant_idx_d;
   logic        lock_drop_d;
   logic        timeout_d;
   logic        owner_valid;
   logic        owner_lock;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_write;
   logic        sel_lock;

   assign owner_valid = grant_q ? s1_valid_i : s0_valid_i;
   assign owner_lock  = grant_q ? s1_lock_i  : s0_lock_i;
   assign timeout_d   = (cnt_q == TIMEOUT_LAST);

   always_comb begin
      grant_en_d  = 1'b0;
      grant_idx_d = 1'b0;
      lock_drop_d = 1'b0;
      if (lock_q) begin
         // Locked: the other requester is invisible until the owner lets go.
         grant_en_d  = owner_valid;
         grant_idx_d = grant_q;
         lock_drop_d = !owner_valid && !owner_lock;
      end else begin
         grant_en_d = s0_valid_i || s1_valid_i;
         if (s0_valid_i && s1_valid_i) begin
            grant_idx_d = ~last_q;
         end else begin
            grant_idx_d = s1_valid_i;
         end
      end
   end

   assign sel_addr  = grant_idx_d ? s1_addr_i  : s0_addr_i;
   assign sel_wdata = grant_idx_d ? s1_wdata_i : s0_wdata_i;
   assign sel_write = grant_idx_d ? s1_write_i : s0_write_i;
   assign sel_lock  = grant_idx_d ? s1_lock_i  : s0_lock_i;

   always_ff @(posedge cpu_clk_i) begin
      if (cpu_reset_i) begin
         state_q     <= ST_IDLE;
         lock_q      <= 1'b0;
         last_q      <= 1'b1;
         grant_q     <= 1'b0;
         cnt_q       <= 8'd0;
         cpu_valid_q <= 1'b0;
         cpu_addr_q  <= 32'd0;
         cpu_wdata_q <= 32'd0;
         cpu_write_q <= 4'd0;
         s0_ready_q  <= 1'b0;
         s1_ready_q  <= 1'b0;
         s0_err_q    <= 1'b0;
         s1_err_q    <= 1'b0;
         s0_rdata_q  <= 32'd0;
         s1_rdata_q  <= 32'd0;
         arb_busy_q  <= 1'b0;
      end else begin
         s0_ready_q <= 1'b0;
         s1_ready_q <= 1'b0;
         s0_err_q   <= 1'b0;
         s1_err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_en_d) begin
                  state_q     <= ST_BUSY;
                  grant_q     <= grant_idx_d;
                  last_q      <= grant_idx_d;
                  lock_q      <= sel_lock;
                  cnt_q       <= 8'd0;
                  cpu_valid_q <= 1'b1;
                  cpu_addr_q  <= sel_addr;
                  cpu_wdata_q <= sel_wdata;
                  cpu_write_q <= sel_write;
                  arb_busy_q  <= 1'b1;
               end else if (lock_drop_d) begin
                  lock_q <= 1'b0;
               end
            end
            ST_BUSY: begin
               cnt_q <= cnt_q + 8'd1;
               // A completion in the same cycle as the timeout is a normal finish.
               if (cpu_ready_i) begin
                  state_q     <= ST_RELEASE;
                  cpu_valid_q <= 1'b0;
                  if (grant_q) begin
                     s1_ready_q <= 1'b1;
                     s1_rdata_q <= cpu_rdata_i;
                  end else begin
                     s0_ready_q <= 1'b1;
                     s0_rdata_q <= cpu_rdata_i;
                  end
               end else if (timeout_d) begin
                  state_q     <= ST_RELEASE;
                  cpu_valid_q <= 1'b0;
                  lock_q      <= 1'b0;
                  if (grant_q) begin
                     s1_ready_q <= 1'b1;
                     s1_err_q   <= 1'b1;
                     s1_rdata_q <= ERR_RDATA;
                  end else begin
                     s0_ready_q <= 1'b1;
                     s0_err_q   <= 1'b1;
                     s0_rdata_q <= ERR_RDATA;
                  end
               end
            end
            ST_RELEASE: begin
               state_q    <= ST_IDLE;
               arb_busy_q <= 1'b0;
            end
            default: begin
               state_q     <= ST_IDLE;
               cpu_valid_q <= 1'b0;
               arb_busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s0_ready_o  = s0_ready_q;
   assign s1_ready_o  = s1_ready_q;
   assign s0_err_o    = s0_err_q;
   assign s1_err_o    = s1_err_q;
   assign s0_rdata_o  = s0_rdata_q;
   assign s1_rdata_o  = s1_rdata_q;
   assign cpu_valid_o = cpu_valid_q;
   assign cpu_addr_o  = cpu_addr_q;
   assign cpu_wdata_o = cpu_wdata_q;
   assign cpu_write_o = cpu_write_q;
   assign cpu_lock_o  = lock_q;
   assign arb_grant_o = grant_q;
   assign arb_busy_o  = arb_busy_q;

endmodule
